// File: rtl/delta_trace_buffer.sv
// Circular trace buffer fed by the delta compressor, with an oldest-first drain over valid/ready.
// Optional macro DELTA_TB_WRAP_FLAG_EN adds the 'wrapped' output (set when the oldest entry was overwritten).
module delta_trace_buffer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TB_SIZE    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tracing,
  input  logic                            valid_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]    vector_in,
  input  logic                            comp_in,
  input  logic                            inc_tb_ptr,
  input  logic                            drain_req,
  input  logic                            ready_in,
  output logic                            valid_out,
  output logic [N-1:0][DATA_WIDTH-1:0]    vector_out,
  output logic                            comp_out,
  output logic                            last_out,
  output logic                            busy,
  output logic [$clog2(TB_SIZE):0]        count
`ifdef DELTA_TB_WRAP_FLAG_EN
  ,
  output logic                            wrapped
`endif
);

  localparam int PW = $clog2(TB_SIZE);
  localparam int EW = N * DATA_WIDTH + 1;
  localparam logic [PW:0] FULL = (PW + 1)'(TB_SIZE);
  localparam logic [PW:0] ONE  = (PW + 1)'(1);
  localparam logic [PW:0] TWO  = (PW + 1)'(2);

  typedef enum logic [1:0] {S_IDLE, S_TRACE, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [PW:0]     remaining_q, remaining_d;
  logic            slot_open_q, slot_open_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [EW-1:0]   data_q, data_d;

  // Each entry is {comp flag, vector}.
  logic [EW-1:0]   mem_q [0:TB_SIZE-1];
  logic            mem_we;
  logic [PW-1:0]   mem_waddr;
  logic [PW-1:0]   rd_next;

  logic            trace_entry;
  logic            new_slot_write;
  logic            drain_done;

  assign rd_next = rd_ptr_q + PW'(1);

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    remaining_d    = remaining_q;
    slot_open_d    = slot_open_q;
    valid_d        = valid_q;
    last_d         = last_q;
    data_d         = data_q;
    mem_we         = 1'b0;
    mem_waddr      = wr_ptr_q;
    trace_entry    = 1'b0;
    new_slot_write = 1'b0;
    drain_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tracing) begin
          trace_entry = 1'b1;
          state_d     = S_TRACE;
          count_d     = '0;
          slot_open_d = 1'b0;
          wr_ptr_d    = '1;
        end else if (drain_req && (count_q != '0)) begin
          state_d     = S_DRAIN;
          rd_ptr_d    = wr_ptr_q - PW'(count_q) + PW'(1);
          remaining_d = count_q;
        end
      end

      S_TRACE: begin
        if (valid_in) begin
          mem_we = 1'b1;
          if (inc_tb_ptr || !slot_open_q) begin
            new_slot_write = 1'b1;
            mem_waddr      = wr_ptr_q + PW'(1);
            wr_ptr_d       = wr_ptr_q + PW'(1);
            slot_open_d    = 1'b1;
            if (count_q != FULL) begin
              count_d = count_q + ONE;
            end
          end
        end
        if (!tracing) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        // First cycle in DRAIN primes the output registers; afterwards each handshake refills them.
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          last_d  = (remaining_q == ONE);
        end else if (ready_in) begin
          if (last_q) begin
            drain_done  = 1'b1;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            count_d     = '0;
            slot_open_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            rd_ptr_d    = rd_next;
            remaining_d = remaining_q - ONE;
            data_d      = mem_q[rd_next];
            last_d      = (remaining_q == TWO);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '1;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      slot_open_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      slot_open_q <= slot_open_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= {comp_in, vector_in};
    end
  end

`ifdef DELTA_TB_WRAP_FLAG_EN
  logic wrapped_q;

  always_ff @(posedge clk) begin
    if (rst || trace_entry || drain_done) begin
      wrapped_q <= 1'b0;
    end else if (new_slot_write && (count_q == FULL)) begin
      wrapped_q <= 1'b1;
    end
  end

  assign wrapped = wrapped_q;
`endif

  assign valid_out             = valid_q;
  assign {comp_out, vector_out} = data_q;
  assign last_out              = last_q;
  assign busy                  = (state_q == S_DRAIN);
  assign count                 = count_q;

endmodule

// File: tb/tb_delta_trace_buffer.sv
// Self-checking bench for delta_trace_buffer: directed scenarios plus randomized trace/drain rounds
// checked against a queue-based model of the stored entries.
module tb_delta_trace_buffer;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int TB = 4;

  typedef logic [N*DW-1:0] vec_t;
  typedef logic [N*DW:0]   ent_t;   // {comp, vector}
  typedef logic [N*DW+1:0] obs_t;   // {last, comp, vector}

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tracing;
  logic                 valid_in;
  logic [N-1:0][DW-1:0] vector_in;
  logic                 comp_in;
  logic                 inc_tb_ptr;
  logic                 drain_req;
  logic                 ready_in;
  logic                 valid_out;
  logic [N-1:0][DW-1:0] vector_out;
  logic                 comp_out;
  logic                 last_out;
  logic                 busy;
  logic [2:0]           count;
`ifdef DELTA_TB_WRAP_FLAG_EN
  logic                 wrapped;
`endif

  delta_trace_buffer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .comp_in    (comp_in),
    .inc_tb_ptr (inc_tb_ptr),
    .drain_req  (drain_req),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .vector_out (vector_out),
    .comp_out   (comp_out),
    .last_out   (last_out),
    .busy       (busy),
    .count      (count)
`ifdef DELTA_TB_WRAP_FLAG_EN
    ,
    .wrapped    (wrapped)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: the stored entries, oldest first.
  ent_t m_q[$];
  bit   m_open;
  bit   m_wrap;
  obs_t obs_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    m_q.delete();
    m_open = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic start_trace();
    tracing = 1'b1;
    tick();
    m_clear();
  endtask

  task automatic stop_trace();
    tracing = 1'b0;
    tick();
  endtask

  task automatic wr(input bit inc, input vec_t v, input bit c);
    valid_in   = 1'b1;
    inc_tb_ptr = inc;
    vector_in  = v;
    comp_in    = c;
    tick();
    valid_in   = 1'b0;
    inc_tb_ptr = 1'b0;
    if (inc || !m_open) begin
      if (m_q.size() == TB) begin
        m_wrap = 1'b1;
        void'(m_q.pop_front());
      end
      m_q.push_back({c, v});
      m_open = 1'b1;
    end else begin
      m_q[m_q.size()-1] = {c, v};
    end
  endtask

  // Runs a drain with random backpressure and records every accepted entry.
  task automatic drain_collect(input int ready_pct, output bit timed_out);
    obs_q.delete();
    timed_out = 1'b1;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    for (int c = 0; c < 80; c++) begin
      ready_in = ($urandom_range(99) < ready_pct);
      if (valid_out && ready_in) begin
        obs_q.push_back({last_out, comp_out, vector_out});
        if (last_out) begin
          tick();
          timed_out = 1'b0;
          break;
        end
      end
      tick();
    end
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({valid_out, last_out, busy, comp_out, count, vector_out} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h want=0", {valid_out, last_out, busy, comp_out, count, vector_out});
    end
    $display("reset: count=%0d busy=%0b valid_out=%0b", count, busy, valid_out);
  endtask

  task automatic test_basic_drain();
    bit to;
    obs_t exp;
    start_trace();
    wr(1'b1, {8'd1, 8'd1}, 1'b0);
    wr(1'b1, {8'd2, 8'd2}, 1'b0);
    wr(1'b1, {8'd3, 8'd3}, 1'b0);
    stop_trace();
    n_cmp++;
    if (count !== 3'd3) begin n_err++; $display("FAIL basic_count got=%0d want=3", count); end
    drain_collect(100, to);
    n_cmp++;
    if (to || obs_q.size() != 3) begin
      n_err++; $display("FAIL basic_len got=%0d want=3 timeout=%0b", obs_q.size(), to);
    end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      exp = {(i == 2), 1'b0, 8'(i + 1), 8'(i + 1)};
      n_cmp++;
      if (obs_q[i] !== exp) begin n_err++; $display("FAIL basic_entry%0d got=%h want=%h", i, obs_q[i], exp); end
    end
    n_cmp++;
    if ({count, busy, valid_out} !== 5'b0) begin
      n_err++; $display("FAIL basic_after got=%0d/%0b/%0b want=0/0/0", count, busy, valid_out);
    end
    m_clear();
    $display("basic drain: %0d entries read", obs_q.size());
  endtask

  task automatic test_overwrite();
    bit to;
    obs_t exp;
    start_trace();
    wr(1'b1, {8'h40, 8'h40}, 1'b1);
    wr(1'b0, {8'h41, 8'h41}, 1'b1);
    wr(1'b0, {8'h42, 8'h42}, 1'b1);
    stop_trace();
    n_cmp++;
    if (count !== 3'd1) begin n_err++; $display("FAIL overwrite_count got=%0d want=1", count); end
    drain_collect(100, to);
    exp = {1'b1, 1'b1, 8'h42, 8'h42};
    n_cmp++;
    if (to || obs_q.size() != 1 || obs_q[0] !== exp) begin
      n_err++; $display("FAIL overwrite_entry got_len=%0d got=%h want=%h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp);
    end
    m_clear();
    $display("overwrite: single entry read");
  endtask

  task automatic test_wrap();
    bit to;
    obs_t exp;
    start_trace();
    for (int v = 1; v <= 6; v++) wr(1'b1, {8'(v), 8'(v)}, 1'b0);
    stop_trace();
    n_cmp++;
    if (count !== 3'd4) begin n_err++; $display("FAIL wrap_count got=%0d want=4", count); end
`ifdef DELTA_TB_WRAP_FLAG_EN
    n_cmp++;
    if (wrapped !== 1'b1) begin n_err++; $display("FAIL wrap_flag_before got=%0b want=1", wrapped); end
`endif
    drain_collect(100, to);
    n_cmp++;
    if (to || obs_q.size() != 4) begin n_err++; $display("FAIL wrap_len got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      exp = {(i == 3), 1'b0, 8'(i + 3), 8'(i + 3)};
      n_cmp++;
      if (obs_q[i] !== exp) begin n_err++; $display("FAIL wrap_entry%0d got=%h want=%h", i, obs_q[i], exp); end
    end
`ifdef DELTA_TB_WRAP_FLAG_EN
    n_cmp++;
    if (wrapped !== 1'b0) begin n_err++; $display("FAIL wrap_flag_after got=%0b want=0", wrapped); end
`endif
    m_clear();
    $display("wrap: %0d entries read after 6 writes", obs_q.size());
  endtask

  task automatic test_backpressure();
    vec_t v0, v1;
    v0 = 16'($urandom);
    v1 = 16'($urandom);
    start_trace();
    wr(1'b1, v0, 1'b1);
    wr(1'b1, v1, 1'b0);
    stop_trace();
    ready_in  = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL bp_entry_cycle got busy=%0b valid=%0b want busy=1 valid=0", busy, valid_out);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      else tick();
      n_cmp++;
      if ({valid_out, last_out, comp_out, vector_out} !== {1'b1, 1'b0, 1'b1, v0}) begin
        n_err++; $display("FAIL bp_hold%0d got=%h want=%h", k, {valid_out, last_out, comp_out, vector_out}, {1'b1, 1'b0, 1'b1, v0});
      end
    end
    ready_in = 1'b1;
    tick();
    n_cmp++;
    if ({valid_out, last_out, comp_out, vector_out} !== {1'b1, 1'b1, 1'b0, v1}) begin
      n_err++; $display("FAIL bp_second got=%h want=%h", {valid_out, last_out, comp_out, vector_out}, {1'b1, 1'b1, 1'b0, v1});
    end
    tick();
    ready_in = 1'b0;
    n_cmp++;
    if ({valid_out, busy, count} !== 5'b0) begin
      n_err++; $display("FAIL bp_done got=%b want=0", {valid_out, busy, count});
    end
    m_clear();
    $display("backpressure: 2 entries read with stall");
  endtask

  task automatic test_ignored();
    bit to;
    obs_t exp;
    start_trace();
    wr(1'b1, 16'h1111, 1'b0);
    wr(1'b1, 16'h2222, 1'b0);
    stop_trace();
    valid_in   = 1'b1;
    inc_tb_ptr = 1'b1;
    vector_in  = 16'hdead;
    for (int k = 0; k < 3; k++) tick();
    valid_in   = 1'b0;
    inc_tb_ptr = 1'b0;
    n_cmp++;
    if (count !== 3'd2 || busy !== 1'b0) begin
      n_err++; $display("FAIL ign_idle_write got count=%0d busy=%0b want 2/0", count, busy);
    end
    start_trace();
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL ign_drain_in_trace got count=%0d busy=%0b want 0/0", count, busy);
    end
    wr(1'b0, 16'h5a5a, 1'b1);
    n_cmp++;
    if (count !== 3'd1) begin n_err++; $display("FAIL ign_first_open got=%0d want=1", count); end
    wr(1'b0, 16'h6b6b, 1'b0);
    stop_trace();
    drain_collect(100, to);
    exp = {1'b1, 1'b0, 16'h6b6b};
    n_cmp++;
    if (to || obs_q.size() != 1 || obs_q[0] !== exp) begin
      n_err++; $display("FAIL ign_drain got_len=%0d got=%h want=%h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp);
    end
    m_clear();
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL ign_empty_drain got busy=%0b valid=%0b want 0/0", busy, valid_out);
    end
    $display("ignored inputs: idle write, drain in trace, empty drain checked");
  endtask

  task automatic test_rst_mid_drain();
    start_trace();
    wr(1'b1, 16'h0101, 1'b0);
    wr(1'b1, 16'h0202, 1'b0);
    stop_trace();
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({valid_out, busy, count} !== 5'b0) begin
      n_err++; $display("FAIL rst_drain got=%b want=0", {valid_out, busy, count});
    end
    m_clear();
    $display("reset mid-drain: valid_out=%0b busy=%0b count=%0d", valid_out, busy, count);
  endtask

  task automatic test_random();
    bit to;
    obs_t exp;
    int nw;
    for (int r = 0; r < 20; r++) begin
      start_trace();
      nw = $urandom_range(1, 10);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(3) == 0) tick();
        wr(1'($urandom), 16'($urandom), 1'($urandom));
      end
      stop_trace();
      n_cmp++;
      if (count !== 3'(m_q.size())) begin
        n_err++; $display("FAIL rnd%0d_count got=%0d want=%0d", r, count, m_q.size());
      end
`ifdef DELTA_TB_WRAP_FLAG_EN
      n_cmp++;
      if (wrapped !== m_wrap) begin n_err++; $display("FAIL rnd%0d_wrapped got=%0b want=%0b", r, wrapped, m_wrap); end
`endif
      drain_collect(60, to);
      n_cmp++;
      if (to || obs_q.size() != m_q.size()) begin
        n_err++; $display("FAIL rnd%0d_len got=%0d want=%0d timeout=%0b", r, obs_q.size(), m_q.size(), to);
      end
      for (int i = 0; i < obs_q.size() && i < m_q.size(); i++) begin
        exp = {(i == m_q.size() - 1), m_q[i]};
        n_cmp++;
        if (obs_q[i] !== exp) begin n_err++; $display("FAIL rnd%0d_entry%0d got=%h want=%h", r, i, obs_q[i], exp); end
      end
      n_cmp++;
      if ({count, busy} !== 4'b0) begin n_err++; $display("FAIL rnd%0d_after got=%b want=0", r, {count, busy}); end
      $display("random round %0d: %0d writes, %0d entries drained", r, nw, obs_q.size());
      m_clear();
    end
  endtask

  initial begin
    rst        = 1'b1;
    tracing    = 1'b0;
    valid_in   = 1'b0;
    vector_in  = '0;
    comp_in    = 1'b0;
    inc_tb_ptr = 1'b0;
    drain_req  = 1'b0;
    ready_in   = 1'b0;
    m_clear();
    test_reset();
    test_basic_drain();
    test_overwrite();
    test_wrap();
    test_backpressure();
    test_ignored();
    test_rst_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
